// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store sequencer: op field layout,
// access size codes, FSM states and the request legality check.
package lsu_pkg;

    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_UNS   = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStore = 3'd2,
        StRmwRd = 3'd3,
        StRmwWr = 3'd4
    } lsu_state_e;

    // Size 11 is illegal; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic op_legal(logic [1:0] size, logic [1:0] lane);
        logic ok;
        unique case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lane[0];
            SZ_W:    ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-addressed data memory bus between the load/store sequencer and dmem.
interface dmem_lsu_if;
    logic        mem_cs;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs, mem_r, mem_w, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends a load result, and merges
// sub-word store data into a read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_B:    load_data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merge_data = word;
        case (size)
            SZ_B: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (lane[1]) merge_data[31:16] = wdata[15:0];
                else         merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer: alignment check, word indexing, load extension and
// read-modify-write for sub-word stores into a whole-word-write dmem.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned WIDX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    dmem_lsu_if.master  mem
);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, merge_q, merge_d, rdata_q, rdata_d;
    logic        done_q, done_d, err_q, err_d, capture;
    logic [31:0] load_data, merge_data;
    logic        unused_bits;

    assign unused_bits = ^{addr_q[31:WIDX_W+2], op_q[OP_STORE]};

    lsu_lane u_lane (
        .word       (mem.mem_rdata),
        .lane       (addr_q[1:0]),
        .size       (op_q[1:0]),
        .uns        (op_q[OP_UNS]),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (op_legal(op[1:0], addr[1:0])) begin
                        capture = 1'b1;
                        if (!op[OP_STORE])        state_d = StLoad;
                        else if (op[1:0] == SZ_W) state_d = StStore;
                        else                      state_d = StRmwRd;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_data;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StStore: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StRmwRd: begin
                merge_d = merge_data;
                state_d = StRmwWr;
            end
            StRmwWr: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (capture) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Strobes decode from state alone so an async reset aborts a write at once.
    always_comb begin
        busy          = (state_q != StIdle);
        mem.mem_cs    = busy;
        mem.mem_r     = (state_q == StLoad) || (state_q == StRmwRd);
        mem.mem_w     = (state_q == StStore) || (state_q == StRmwWr);
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (busy) begin
            mem.mem_addr  = {{(32 - WIDX_W){1'b0}}, addr_q[WIDX_W+1:2]};
            mem.mem_wdata = (state_q == StRmwWr) ? merge_q : wdata_q;
        end
    end

    assign rdata    = rdata_q;
    assign done     = done_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

    localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100, OP_LHU = 4'b0101, OP_ILL = 4'b0011;
    localparam logic [3:0] OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [3:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, addr_err;

    dmem_lsu_if bus ();

    dmem_lsu #(.WIDX_W(8)) dut (
        .clk      (clk),
        .reset    (reset_n),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .addr_err (addr_err),
        .mem      (bus.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          cyc = 0, wr_cnt = 0, cs_cnt = 0, last_wcyc = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;

    assign bus.mem_rdata = (bus.mem_cs && bus.mem_r) ? mem[bus.mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_cs) cs_cnt <= cs_cnt + 1;
        if (bus.mem_cs && bus.mem_w) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bus.mem_addr;
            last_wdata <= bus.mem_wdata;
            last_wcyc  <= cyc;
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_fail = 0, n_issued = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc - e.issue, e.lat);
                chk("addr_err", {31'h0, addr_err}, {31'h0, e.err});
                chk("rdata", rdata, e.rd);
            end
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic err, input int lat);
        exp_t e;
        e.rd = rd; e.err = err; e.issue = cyc; e.lat = lat;
        sb.push_back(e);
        n_issued++;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input logic err, input int lat,
                         input bit hold, output int at);
        req = 1'b1; op = o; addr = a; wdata = d;
        at = cyc;
        push_exp(rd, err, lat);
        wait_done();
        if (!hold) req = 1'b0;
    endtask

    int t, t0, cs0, wc0;

    initial begin
        reset_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cs", {31'h0, bus.mem_cs}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, t);
        chk("sw_waddr", last_waddr, 32'd4);
        chk("sw_wcyc", last_wcyc, t + 1);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        issue(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, t);

        issue(OP_SW, 32'h10, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 2, 0, t);
        issue(OP_LB, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, t);
        issue(OP_LBU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 0, t);
        issue(OP_LH, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, t);
        issue(OP_LHU, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2, 0, t);

        issue(OP_SW, 32'h10, 32'h11223344, 32'h00007F01, 1'b0, 2, 0, t);
        issue(OP_SB, 32'h11, 32'h000000AA, 32'h00007F01, 1'b0, 3, 0, t);
        chk("sb_wdata", last_wdata, 32'h1122AA44);
        chk("sb_wcyc", last_wcyc, t + 2);
        issue(OP_SH, 32'h12, 32'h0000BEEF, 32'h00007F01, 1'b0, 3, 0, t);
        chk("sh_wdata", last_wdata, 32'hBEEFAA44);
        issue(OP_LW, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0, t);

        cs0 = cs_cnt;
        issue(OP_LW, 32'h12, 32'h0, 32'hBEEFAA44, 1'b1, 1, 0, t);
        issue(OP_SH, 32'h13, 32'h1234, 32'hBEEFAA44, 1'b1, 1, 0, t);
        issue(OP_ILL, 32'h10, 32'h0, 32'hBEEFAA44, 1'b1, 1, 0, t);
        chk("err_no_cs", cs_cnt, cs0);

        // Abort a read-modify-write while the write strobe is up.
        req = 1'b1; op = OP_SB; addr = 32'h10; wdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rmw_wr_strobe", {31'h0, bus.mem_w}, 32'h1);
        wc0 = wr_cnt;
        reset_n = 1'b0;
        #1;
        chk("abort_mem_w", {31'h0, bus.mem_w}, 32'h0);
        chk("abort_mem_cs", {31'h0, bus.mem_cs}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        chk("abort_no_write", wr_cnt, wc0);
        chk("abort_word", mem[4], 32'hBEEFAA44);
        reset_n = 1'b1;
        @(negedge clk);
        issue(OP_LW, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0, t);

        issue(OP_SW, 32'h14, 32'h12345678, 32'hBEEFAA44, 1'b0, 2, 0, t);
        issue(OP_SW, 32'h18, 32'hCAFEF00D, 32'hBEEFAA44, 1'b0, 2, 0, t);
        issue(OP_LW, 32'h14, 32'h0, 32'h12345678, 1'b0, 2, 1, t0);
        issue(OP_LW, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, t);
        issue(OP_LW, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 2, 0, t);
        chk("b2b_total", cyc, t0 + 6);

        // Sub-word store with a one-cycle req pulse during RMW_WR.
        req = 1'b1; op = OP_SB; addr = 32'h14; wdata = 32'h99;
        push_exp(32'hBEEFAA44, 1'b0, 3);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("pulse_busy", {31'h0, busy}, 32'h1);
        req = 1'b1; op = OP_LW; addr = 32'h18;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        chk("done_count", done_cnt, n_issued);
        chk("sb_empty", sb.size(), 32'd0);
        issue(OP_LW, 32'h14, 32'h0, 32'h12345699, 1'b0, 2, 0, t);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
